// File: rtl/bitscan_unit.sv
// bitscan_unit: iterative CLZ / CTZ / CPOP unit.
// Holds a latched copy of the operand and shifts it by CHUNK bits every cycle,
// so the chunk under examination is always at a fixed position: the top CHUNK
// bits for CLZ, the bottom CHUNK bits for CTZ and CPOP.
module bitscan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  parameter int BITS  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int NCH = WIDTH / CHUNK;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [1:0]       r_op;
  logic [BITS:0]    r_count;
  logic [BITS:0]    r_idx;

  logic [CHUNK-1:0] w_chunk;
  logic [BITS:0]    w_lz;
  logic [BITS:0]    w_tz;
  logic [BITS:0]    w_pc;
  logic             w_lz_found;
  logic             w_tz_found;
  logic [BITS:0]    w_add;
  logic [BITS:0]    w_sum;
  logic             w_last;
  logic             w_finish;

  // Select the chunk currently under examination.
  always_comb begin
    w_chunk = (r_op == OP_CLZ) ? r_shreg[WIDTH-1 -: CHUNK] : r_shreg[CHUNK-1:0];
  end

  // Per-chunk leading zeros, trailing zeros and population count.
  always_comb begin
    w_lz       = '0;
    w_tz       = '0;
    w_pc       = '0;
    w_lz_found = 1'b0;
    w_tz_found = 1'b0;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (!w_lz_found) begin
        if (w_chunk[j]) w_lz_found = 1'b1;
        else            w_lz = w_lz + (BITS+1)'(1);
      end
    end
    for (int j = 0; j < CHUNK; j++) begin
      if (!w_tz_found) begin
        if (w_chunk[j]) w_tz_found = 1'b1;
        else            w_tz = w_tz + (BITS+1)'(1);
      end
      w_pc = w_pc + (BITS+1)'(w_chunk[j]);
    end
  end

  // Contribution of this cycle and whether the scan ends here.
  // An all-zero chunk yields CHUNK from the zero-counting loops above.
  always_comb begin
    w_last = (r_idx == (BITS+1)'(NCH - 1));
    case (r_op)
      OP_CLZ: begin
        w_add    = w_lz;
        w_finish = w_lz_found | w_last;
      end
      OP_CTZ: begin
        w_add    = w_tz;
        w_finish = w_tz_found | w_last;
      end
      OP_CPOP: begin
        w_add    = w_pc;
        w_finish = w_last;
      end
      default: begin
        w_add    = '0;
        w_finish = 1'b1;
      end
    endcase
    w_sum = r_count + w_add;
  end

  // Control FSM, datapath registers and registered handshakes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_op     <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            r_shreg <= i_operand;
            r_op    <= i_op;
            r_count <= '0;
            r_idx   <= '0;
            o_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_count <= w_sum;
          r_idx   <= r_idx + (BITS+1)'(1);
          r_shreg <= (r_op == OP_CLZ) ? (r_shreg << CHUNK) : (r_shreg >> CHUNK);
          if (w_finish) begin
            o_result <= WIDTH'(w_sum);
            o_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
